// File: rtl/mips_register_file_if.sv
// Register-file access bundle: two operand read ports, one write port,
// a debug read port and the committed-write counter.
interface mips_register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [15:0]       wr_count;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dbg_addr,
        input  rd_data_a, rd_data_b, dbg_data, wr_count
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dbg_addr,
        output rd_data_a, rd_data_b, dbg_data, wr_count
    );
endinterface

// File: rtl/mips_register_file.sv
// 32x32 MIPS register file: two combinational operand ports with optional
// write-to-read forwarding, an unbypassed debug port and a saturating write counter.
module mips_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_register_file_if.slave  rf
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [15:0]       wr_count_reg;
    logic              wr_commit;

    // Address 0 is hard-wired, so a write there is neither stored nor counted.
    assign wr_commit = rf.wr_en && (rf.wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            wr_count_reg <= '0;
        end else if (wr_commit) begin
            regs_reg[rf.wr_addr] <= rf.wr_data;
            if (wr_count_reg != 16'hFFFF) begin
                wr_count_reg <= wr_count_reg + 16'd1;
            end
        end
    end

    logic [ADDR_W-1:0] rd_addr [2];
    assign rd_addr[0] = rf.rd_addr_a;
    assign rd_addr[1] = rf.rd_addr_b;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
        logic [DATA_W-1:0] data;
        always_comb begin
            data = '0;
            if (rst_n && (rd_addr[gi] != '0)) begin
                // Forward the in-flight write so the consumer sees it this cycle.
                if ((BYPASS != 0) && wr_commit && (rd_addr[gi] == rf.wr_addr)) begin
                    data = rf.wr_data;
                end else begin
                    data = regs_reg[rd_addr[gi]];
                end
            end
        end
    end

    assign rf.rd_data_a = g_rd_port[0].data;
    assign rf.rd_data_b = g_rd_port[1].data;
    assign rf.dbg_data  = (rst_n && (rf.dbg_addr != '0)) ? regs_reg[rf.dbg_addr] : '0;
    assign rf.wr_count  = wr_count_reg;
endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench: one bypassing and one non-bypassing register file share stimulus;
// a vector table covers the main cases, hand sequences cover reset, sweep and saturation.
module tb_mips_register_file;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mips_register_file_if #(.DATA_W(32), .ADDR_W(5)) if1 ();
    mips_register_file_if #(.DATA_W(32), .ADDR_W(5)) if0 ();

    assign if0.rd_addr_a = if1.rd_addr_a;
    assign if0.rd_addr_b = if1.rd_addr_b;
    assign if0.wr_en     = if1.wr_en;
    assign if0.wr_addr   = if1.wr_addr;
    assign if0.wr_data   = if1.wr_data;
    assign if0.dbg_addr  = if1.dbg_addr;

    mips_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .rf(if1.slave)
    );
    mips_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nobyp (
        .clk(clk), .rst_n(rst_n), .rf(if0.slave)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  da;
        logic [31:0] exp_a1;
        logic [31:0] exp_b1;
        logic [31:0] exp_a0;
        logic [31:0] exp_b0;
        logic [31:0] exp_dbg;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] da);
        if1.wr_en = we; if1.wr_addr = wa; if1.wr_data = wd;
        if1.rd_addr_a = ra; if1.rd_addr_b = rb; if1.dbg_addr = da;
    endtask

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic [4:0] ra,
                                logic [4:0] rb, logic [4:0] da, logic [31:0] a1, logic [31:0] b1,
                                logic [31:0] a0, logic [31:0] b0, logic [31:0] dg, logic [15:0] c);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb; v.da = da;
        v.exp_a1 = a1; v.exp_b1 = b1; v.exp_a0 = a0; v.exp_b0 = b0;
        v.exp_dbg = dg; v.exp_cnt = c;
        return v;
    endfunction

    initial begin
        // Expected values are the pre-edge combinational outputs of each vector.
        vecs[0]  = mk(1, 8, 32'hDEADBEEF, 8, 9, 8, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 9, 32'hCAFEBABE, 8, 9, 9, 32'hDEADBEEF, 32'hCAFEBABE, 32'hDEADBEEF, 0, 0, 1);
        vecs[2]  = mk(0, 0, 0, 8, 9, 9, 32'hDEADBEEF, 32'hCAFEBABE, 32'hDEADBEEF, 32'hCAFEBABE, 32'hCAFEBABE, 2);
        vecs[3]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        vecs[4]  = mk(0, 0, 32'hFFFFFFFF, 0, 8, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 2);
        vecs[5]  = mk(1, 5, 32'h12345678, 5, 5, 5, 32'h12345678, 32'h12345678, 0, 0, 0, 2);
        vecs[6]  = mk(1, 5, 32'h87654321, 5, 5, 5, 32'h87654321, 32'h87654321, 32'h12345678, 32'h12345678, 32'h12345678, 3);
        vecs[7]  = mk(1, 3, 32'h55555555, 5, 3, 5, 32'h87654321, 32'h55555555, 32'h87654321, 0, 32'h87654321, 4);
        for (int i = 8; i < 12; i++)
            vecs[i] = mk(0, 3, 32'hAAAAAAAA, 3, 3, 3, 32'h55555555, 32'h55555555, 32'h55555555, 32'h55555555, 32'h55555555, 5);
        vecs[12] = mk(0, 0, 0, 3, 5, 3, 32'h55555555, 32'h87654321, 32'h55555555, 32'h87654321, 32'h55555555, 5);

        // Reset state: writes ignored, outputs zero while rst_n is low.
        drive(1, 4, 32'h11111111, 4, 4, 4);
        @(posedge clk); #1;
        check("reset_rd_a", if1.rd_data_a, 0);
        check("reset_dbg", if1.dbg_data, 0);
        check("reset_cnt", {16'h0, if1.wr_count}, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb, vecs[i].da);
            #1;
            check($sformatf("v%0d_byp_a", i), if1.rd_data_a, vecs[i].exp_a1);
            check($sformatf("v%0d_byp_b", i), if1.rd_data_b, vecs[i].exp_b1);
            check($sformatf("v%0d_nob_a", i), if0.rd_data_a, vecs[i].exp_a0);
            check($sformatf("v%0d_nob_b", i), if0.rd_data_b, vecs[i].exp_b0);
            check($sformatf("v%0d_dbg", i), if1.dbg_data, vecs[i].exp_dbg);
            check($sformatf("v%0d_cnt", i), {16'h0, if1.wr_count}, {16'h0, vecs[i].exp_cnt});
            $display("vec %0d we=%0b wa=%0d wd=%h a=%h b=%h dbg=%h cnt=%0d", i, vecs[i].we,
                     vecs[i].wa, vecs[i].wd, if1.rd_data_a, if1.rd_data_b, if1.dbg_data, if1.wr_count);
        end

        // Full sweep r1..r31, then debug readback of every entry.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(1, 5'(i), 32'hFACE0000 | 32'(i), 0, 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 32; i++) begin
            if1.dbg_addr = 5'(i);
            #1;
            check($sformatf("sweep_r%0d", i), if1.dbg_data, 32'hFACE0000 | 32'(i));
        end
        check("sweep_cnt", {16'h0, if1.wr_count}, 36);
        $display("sweep done cnt=%0d", if1.wr_count);

        // Unknown write strobe must leave other registers alone.
        @(negedge clk);
        if1.wr_en = 1'bx; if1.wr_addr = 10; if1.wr_data = 32'h0BAD0BAD;
        @(negedge clk);
        drive(0, 0, 0, 9, 11, 12);
        #1;
        check("xen_r9", if1.rd_data_a, 32'hFACE0009);
        check("xen_r11", if1.rd_data_b, 32'hFACE000B);
        check("xen_r12", if1.dbg_data, 32'hFACE000C);
        $display("x-strobe check r9=%h r11=%h", if1.rd_data_a, if1.rd_data_b);

        // Asynchronous mid-cycle reset with a write pending: reset wins.
        @(negedge clk);
        drive(1, 7, 32'h00000077, 7, 7, 0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            if0.dbg_addr = 5'(i);
            if1.dbg_addr = 5'(i);
            #0;
            check($sformatf("arst_r%0d", i), if1.dbg_data, 0);
        end
        check("arst_byp_a", if1.rd_data_a, 0);
        check("arst_cnt", {16'h0, if1.wr_count}, 0);
        @(posedge clk); #1;
        if1.dbg_addr = 7; #1;
        check("arst_edge_r7", if1.dbg_data, 0);
        // Release with the write still asserted: it commits on the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(0, 0, 0, 7, 0, 7);
        #1;
        check("rel_r7", if1.dbg_data, 32'h00000077);
        check("rel_cnt", {16'h0, if1.wr_count}, 1);
        $display("reset release r7=%h cnt=%0d", if1.dbg_data, if1.wr_count);

        // Drive the counter to saturation, then confirm writes still land.
        for (int i = 0; i < 65533; i++) begin
            @(negedge clk);
            drive(1, 1, 32'(i), 0, 0, 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1);
        #1;
        check("sat_fffe", {16'h0, if1.wr_count}, 32'h0000FFFE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, 1, 32'hC0DE0000 | 32'(i), 0, 0, 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1);
        #1;
        check("sat_ffff", {16'h0, if1.wr_count}, 32'h0000FFFF);
        check("sat_nob_ffff", {16'h0, if0.wr_count}, 32'h0000FFFF);
        check("sat_r1", if1.dbg_data, 32'hC0DE0003);
        $display("saturation cnt=%h r1=%h", if1.wr_count, if1.dbg_data);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
